// File: rtl/ui_pkg.sv
// Shared types and header-word layout for the peripheral TX arbiter.
package ui_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2
  } state_e;

  localparam logic [7:0]  HDR_MAGIC     = 8'hA5;
  localparam int unsigned HDR_MAGIC_LSB = 24;
  localparam int unsigned HDR_ID_LSB    = 16;
  localparam int unsigned HDR_ID_W      = 4;
  localparam int unsigned HDR_LEN_LSB   = 0;
  localparam int unsigned HDR_LEN_W     = 16;

  // Assemble the burst header: magic | 4'h0 | peripheral id | burst length.
  function automatic logic [31:0] make_hdr(input logic [HDR_ID_W-1:0]  id,
                                           input logic [HDR_LEN_W-1:0] len);
    logic [31:0] w;
    w = '0;
    w[HDR_MAGIC_LSB +: 8]      = HDR_MAGIC;
    w[HDR_ID_LSB +: HDR_ID_W]  = id;
    w[HDR_LEN_LSB +: HDR_LEN_W] = len;
    return w;
  endfunction

endpackage

// File: rtl/rr_select.sv
// Round-robin requester search: first set request at or after ptr, modulo N.
module rr_select #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic             found_o,
  output logic [IDX_W-1:0] idx_o
);

  // Walk N candidates starting at ptr; the first hit wins.
  always_comb begin
    int unsigned j;
    found_o = 1'b0;
    idx_o   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      j = 32'(ptr_i) + k;
      if (j >= N) j = j - N;
      if (!found_o && req_i[IDX_W'(j)]) begin
        found_o = 1'b1;
        idx_o   = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/periph_tx_arbiter.sv
// Round-robin arbiter merging peripheral TX FIFOs into one header-framed
// word stream for the FT601 host-bound path.
module periph_tx_arbiter
  import ui_pkg::*;
#(
  parameter int unsigned NUM_PERIPHS = 4,
  parameter int unsigned MAX_BURST   = 16,
  parameter int unsigned LVL_W       = 16
) (
  input  logic                         clk,
  input  logic                         rst_l,
  input  logic                         enable,
  input  logic [NUM_PERIPHS-1:0]       periph_valid,
  input  logic [NUM_PERIPHS*LVL_W-1:0] periph_level,
  input  logic [NUM_PERIPHS*32-1:0]    periph_data,
  input  logic [NUM_PERIPHS*4-1:0]     periph_be,
  output logic [NUM_PERIPHS-1:0]       periph_pop,
  output logic [31:0]                  data_o,
  output logic [3:0]                   be_o,
  output logic                         periph_data_available,
  input  logic                         read_periph_data,
  output logic                         busy,
  output logic [3:0]                   grant_id
);

  localparam int unsigned IDX_W = $clog2(NUM_PERIPHS);
  localparam int unsigned LEN_W = 16;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   rr_q, rr_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;

  logic [LVL_W-1:0]   lvl_arr  [NUM_PERIPHS];
  logic [31:0]        data_arr [NUM_PERIPHS];
  logic [3:0]         be_arr   [NUM_PERIPHS];
  logic [NUM_PERIPHS-1:0] req;
  logic               sel_found;
  logic [IDX_W-1:0]   sel_idx;
  logic [LVL_W-1:0]   sel_lvl;

  // Unpack the flat per-peripheral buses and form the request vector.
  always_comb begin
    for (int unsigned i = 0; i < NUM_PERIPHS; i++) begin
      lvl_arr[i]  = periph_level[i*LVL_W +: LVL_W];
      data_arr[i] = periph_data[i*32 +: 32];
      be_arr[i]   = periph_be[i*4 +: 4];
      req[i]      = (periph_level[i*LVL_W +: LVL_W] != '0);
    end
  end

  rr_select #(
    .N     (NUM_PERIPHS),
    .IDX_W (IDX_W)
  ) u_rr_select (
    .req_i   (req),
    .ptr_i   (rr_q),
    .found_o (sel_found),
    .idx_o   (sel_idx)
  );

  assign sel_lvl = lvl_arr[sel_idx];

  // State and counter registers; reset abandons any burst in flight.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q <= IDLE;
      rr_q    <= '0;
      grant_q <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and output mux; availability never depends on read_periph_data.
  always_comb begin
    state_d               = state_q;
    rr_d                  = rr_q;
    grant_d               = grant_q;
    len_d                 = len_q;
    cnt_d                 = cnt_q;
    periph_pop            = '0;
    data_o                = '0;
    be_o                  = '0;
    periph_data_available = 1'b0;
    busy                  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (enable && sel_found) begin
          grant_d = sel_idx;
          len_d   = (32'(sel_lvl) > 32'(MAX_BURST)) ? LEN_W'(MAX_BURST) : LEN_W'(sel_lvl);
          state_d = HDR;
        end
      end
      HDR: begin
        busy                  = 1'b1;
        periph_data_available = 1'b1;
        be_o                  = 4'hF;
        data_o                = make_hdr(4'(grant_q), len_q);
        if (read_periph_data) begin
          cnt_d   = len_q;
          state_d = DATA;
        end
      end
      DATA: begin
        busy                  = 1'b1;
        periph_data_available = periph_valid[grant_q];
        data_o                = data_arr[grant_q];
        be_o                  = be_arr[grant_q];
        if (periph_valid[grant_q] && read_periph_data) begin
          periph_pop[grant_q] = 1'b1;
          cnt_d               = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) begin
            state_d = IDLE;
            rr_d    = (grant_q == IDX_W'(NUM_PERIPHS - 1)) ? '0 : grant_q + IDX_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign grant_id = 4'(grant_q);

endmodule

// File: tb/tb_periph_tx_arbiter.sv
// Scoreboard bench for periph_tx_arbiter: peripheral FIFOs are modelled as
// deterministic word sequences; expected words are queued per burst.
module tb_periph_tx_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned MB = 16;
  localparam int unsigned LW = 16;

  logic            clk = 1'b0;
  logic            rst_l = 1'b0;
  logic            enable = 1'b0;
  logic            rd = 1'b0;
  logic [N-1:0]    pvalid;
  logic [N*LW-1:0] plevel;
  logic [N*32-1:0] pdata;
  logic [N*4-1:0]  pbe;
  logic [N-1:0]    pop;
  logic [31:0]     data_o;
  logic [3:0]      be_o;
  logic            avail;
  logic            busy;
  logic [3:0]      gid;

  periph_tx_arbiter #(.NUM_PERIPHS(N), .MAX_BURST(MB), .LVL_W(LW)) dut (
    .clk                   (clk),
    .rst_l                 (rst_l),
    .enable                (enable),
    .periph_valid          (pvalid),
    .periph_level          (plevel),
    .periph_data           (pdata),
    .periph_be             (pbe),
    .periph_pop            (pop),
    .data_o                (data_o),
    .be_o                  (be_o),
    .periph_data_available (avail),
    .read_periph_data      (rd),
    .busy                  (busy),
    .grant_id              (gid)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0]  d;
    logic [3:0]   be;
    logic [N-1:0] pop;
    logic [3:0]   id;
  } exp_t;

  exp_t sb[$];
  int   head[N];
  int   cnt[N];
  int   exp_seq[N];
  bit   stall[N];
  int   xfers;
  int   n_cmp;
  int   n_err;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] wdata(input int i, input int seq);
    return {4'hC, 4'(i), 8'h5A, 16'(seq)};
  endfunction

  function automatic logic [3:0] wbe(input int i, input int seq);
    return 4'(seq * 3 + i) | 4'h1;
  endfunction

  function automatic logic [31:0] hdr(input int i, input int len);
    return {8'hA5, 4'h0, 4'(i), 16'(len)};
  endfunction

  task automatic refresh();
    for (int i = 0; i < N; i++) begin
      pvalid[i]          = (cnt[i] > 0) && !stall[i];
      plevel[i*LW +: LW] = LW'(cnt[i]);
      pdata[i*32 +: 32]  = wdata(i, head[i]);
      pbe[i*4 +: 4]      = wbe(i, head[i]);
    end
  endtask

  task automatic load(input int i, input int n);
    cnt[i] += n;
  endtask

  task automatic expect_burst(input int i, input int len);
    exp_t e;
    e.d = hdr(i, len); e.be = 4'hF; e.pop = '0; e.id = 4'(i);
    sb.push_back(e);
    for (int k = 0; k < len; k++) begin
      e.d   = wdata(i, exp_seq[i]);
      e.be  = wbe(i, exp_seq[i]);
      e.pop = N'(1) << i;
      e.id  = 4'(i);
      sb.push_back(e);
      exp_seq[i]++;
    end
  endtask

  task automatic clear_fifos();
    for (int i = 0; i < N; i++) begin
      head[i] += cnt[i];
      cnt[i] = 0;
      exp_seq[i] = head[i];
      stall[i] = 1'b0;
    end
    sb.delete();
  endtask

  // One clock: check outputs mid-cycle, then apply FIFO pops after the edge.
  task automatic step();
    exp_t e;
    logic [N-1:0] seen_pop;
    seen_pop = '0;
    refresh();
    @(negedge clk);
    if (avail && rd) begin
      chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("data", 64'(data_o), 64'(e.d));
        chk("be", 64'(be_o), 64'(e.be));
        chk("pop", 64'(pop), 64'(e.pop));
        chk("grant_id", 64'(gid), 64'(e.id));
      end
      seen_pop = pop;
      xfers++;
    end else begin
      chk("no_pop", 64'(pop), 64'd0);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (seen_pop[i] && cnt[i] > 0) begin
        head[i]++;
        cnt[i]--;
      end
  endtask

  task automatic run_until_idle(input string tag, input int max);
    for (int k = 0; k < max; k++) begin
      step();
      if (sb.size() == 0 && !busy) break;
    end
    chk({tag, "_sb_drained"}, 64'(sb.size()), 64'd0);
    chk({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  task automatic run_xfers(input int n, input int max);
    int x0;
    x0 = xfers;
    for (int k = 0; k < max; k++) begin
      if (xfers >= x0 + n) break;
      step();
    end
    chk("xfer_budget", 64'(xfers - x0), 64'(n));
  endtask

  initial begin
    n_cmp = 0; n_err = 0; xfers = 0;
    for (int i = 0; i < N; i++) begin
      head[i] = 0; cnt[i] = 0; exp_seq[i] = 0; stall[i] = 1'b0;
    end
    refresh();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_avail", 64'(avail), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_pop", 64'(pop), 64'd0);
    chk("rst_data", 64'(data_o), 64'd0);
    chk("rst_be", 64'(be_o), 64'd0);
    chk("rst_gid", 64'(gid), 64'd0);
    rst_l = 1'b1;

    // Single requester, full burst: header A502_0003 then 3 words
    rd = 1'b1; enable = 1'b1;
    load(2, 3); expect_burst(2, 3);
    chk("p2_hdr_const", 64'(hdr(2, 3)), 64'h0000_0000_A502_0003);
    run_until_idle("single", 20);
    chk("p2_drained", 64'(cnt[2]), 64'd0);

    // Burst cap: level 40 -> bursts of 16, 16, 8
    load(0, 40);
    expect_burst(0, 16); expect_burst(0, 16); expect_burst(0, 8);
    run_until_idle("cap", 80);
    chk("p0_drained", 64'(cnt[0]), 64'd0);

    // Reset mid-DATA after header + 3 words (5 words left)
    load(1, 8); expect_burst(1, 8);
    run_xfers(4, 20);
    rst_l = 1'b0;
    #1;
    chk("midrst_pop", 64'(pop), 64'd0);
    chk("midrst_avail", 64'(avail), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    clear_fifos();
    refresh();
    @(posedge clk); #1;
    chk("midrst_hold_busy", 64'(busy), 64'd0);
    rst_l = 1'b1;

    // Round-robin from rr_ptr=0: P0, P1, P3, then P0, P1, P3 again
    enable = 1'b0;
    step();
    load(0, 2); load(1, 2); load(3, 2);
    expect_burst(0, 2); expect_burst(1, 2); expect_burst(3, 2);
    enable = 1'b1;
    run_until_idle("rr1", 40);
    load(0, 2); load(1, 2); load(3, 2);
    expect_burst(0, 2); expect_burst(1, 2); expect_burst(3, 2);
    run_until_idle("rr2", 40);
    chk("rr_p2_untouched", 64'(exp_seq[2]), 64'(head[2]));

    // Backpressure in HDR and valid drop mid-burst
    rd = 1'b0;
    load(1, 6); expect_burst(1, 6);
    step();
    for (int k = 0; k < 4; k++) begin
      refresh();
      @(negedge clk);
      chk("bp_hdr_avail", 64'(avail), 64'd1);
      chk("bp_hdr_data", 64'(data_o), 64'(hdr(1, 6)));
      chk("bp_hdr_pop", 64'(pop), 64'd0);
      @(posedge clk); #1;
    end
    rd = 1'b1;
    run_xfers(3, 10);
    stall[1] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      refresh();
      @(negedge clk);
      chk("uf_avail", 64'(avail), 64'd0);
      chk("uf_pop", 64'(pop), 64'd0);
      chk("uf_busy", 64'(busy), 64'd1);
      @(posedge clk); #1;
    end
    stall[1] = 1'b0;
    run_until_idle("bp", 20);
    chk("bp_drained", 64'(cnt[1]), 64'd0);

    // Enable gating: rr_ptr=2 so P3 wins; clearing enable mid-burst
    load(3, 3); load(0, 3);
    expect_burst(3, 3);
    run_xfers(2, 10);
    enable = 1'b0;
    run_until_idle("gate", 20);
    for (int k = 0; k < 6; k++) begin
      step();
      chk("gate_no_grant", 64'(busy), 64'd0);
    end
    chk("gate_p0_waiting", 64'(cnt[0]), 64'd3);
    expect_burst(0, 3);
    enable = 1'b1;
    run_until_idle("gate_resume", 20);
    chk("gate_p0_drained", 64'(cnt[0]), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/periph_tx_arbiter.md
Name: periph_tx_arbiter

Overview:
- Shares the FT601 controller's host-bound (write) path among NUM_PERIPHS peripheral TX FIFOs.
- Grants peripherals in round-robin order, one bounded burst per grant.
- Prefixes each burst with a header word carrying the peripheral ID and the burst length.
- Presents a single 32-bit word stream to the FT601 controller through periph_data_available / read_periph_data.

Parameters:
- NUM_PERIPHS, 4, number of requesting peripherals (2..16).
- MAX_BURST, 16, maximum data words per grant (1..65535).
- LVL_W, 16, width of each peripheral's FIFO level input.

Ports:
- clk  in  1  system clock.
- rst_l  in  1  asynchronous active-low reset.
- enable  in  1  allow new grants; a burst already in progress always completes.
- periph_valid  in  NUM_PERIPHS  peripheral i FIFO head word is valid.
- periph_level  in  NUM_PERIPHS*LVL_W  word count in peripheral i FIFO; slice i is [i*LVL_W +: LVL_W].
- periph_data  in  NUM_PERIPHS*32  FIFO head data; slice i is [i*32 +: 32].
- periph_be  in  NUM_PERIPHS*4  byte enables of the head word.
- periph_pop  out  NUM_PERIPHS  one-hot pop strobe to the granted FIFO.
- data_o  out  32  word to the FT601 controller.
- be_o  out  4  byte enables for data_o.
- periph_data_available  out  1  data_o/be_o are valid.
- read_periph_data  in  1  FT601 controller consumes the word this cycle.
- busy  out  1  a grant is active (state is not IDLE).
- grant_id  out  4  ID of the current or last granted peripheral.

Behaviour:
- A word transfers on a clk edge where periph_data_available && read_periph_data.
- Reset (rst_l low, asynchronous):
  - state=IDLE, rr_ptr=0, grant_id=0, len_r=0, cnt_r=0.
  - All outputs are 0: periph_pop, periph_data_available, busy, data_o, be_o.
- Reset mid-burst abandons the burst. No pop is issued after reset asserts.
- State IDLE:
  - A peripheral requests when periph_level[i] != 0.
  - If enable=1 and any peripheral requests, take the first requester searching i = rr_ptr, rr_ptr+1, ... modulo NUM_PERIPHS.
  - Register grant_id=i and len_r = min(periph_level[i], MAX_BURST); go to HDR.
  - Arbitration costs exactly 1 cycle; outputs remain deasserted during IDLE.
- State HDR:
  - periph_data_available=1 and be_o=4'hF.
  - data_o = {8'hA5, 4'h0, grant_id, len_r[15:0]}.
  - On a transfer: cnt_r=len_r, go to DATA. Otherwise hold.
- State DATA:
  - data_o = periph_data[grant_id]; be_o = periph_be[grant_id].
  - periph_data_available = periph_valid[grant_id].
  - periph_pop[grant_id] = periph_valid[grant_id] && read_periph_data; all other pop bits are 0. Pop is combinational, in the same cycle as the transfer.
  - Each transfer decrements cnt_r.
  - A transfer with cnt_r==1 ends the burst: go to IDLE, rr_ptr = grant_id+1 (wraps to 0 at NUM_PERIPHS).
  - If periph_valid drops mid-burst, periph_data_available drops and the arbiter waits indefinitely. It never re-arbitrates until len_r words are sent.
- Level changes after the grant do not alter len_r.
- Clearing enable in HDR or DATA has no effect until the return to IDLE.
- busy=1 in HDR and DATA.
- No combinational path from read_periph_data to periph_data_available.
- Latency, idle request to first header word valid: 1 cycle after the request is seen in IDLE.
- Minimum per-burst overhead: 2 cycles (IDLE + HDR).

Decomposition:
- Shared package ui_pkg:
  - state typedef {IDLE, HDR, DATA}.
  - HDR_MAGIC = 8'hA5.
  - Header field positions.
- One sub-module: rr_select.
  - Combinational masked priority search.
  - Inputs: request vector, rr_ptr. Outputs: found flag, index.
- The FSM, counters and muxing live in periph_tx_arbiter.

Test Plan:
- Reset and idle:
  - Stimulus: rst_l low mid-DATA with cnt_r=5.
  - Required: pop, periph_data_available and busy go 0 immediately; after release, state IDLE, rr_ptr=0.
- Single requester, full burst:
  - Stimulus: P2 level=3, read_periph_data tied 1.
  - Required: header 32'hA502_0003, then 3 data words with pop[2] pulsing 3 cycles, then IDLE.
- Burst cap:
  - Stimulus: P0 level=40, MAX_BURST=16.
  - Required: header 32'hA500_0010, 16 pops, return to IDLE, then re-grant P0 with length 0x0010.
- Round-robin fairness:
  - Stimulus: P0, P1 and P3 all at level=2.
  - Required: grant order P0, P1, P3, P0...; P2 is never granted.
- Backpressure and underflow:
  - Stimulus: read_periph_data low for 4 cycles in HDR; P1 valid drops for 3 cycles mid-burst.
  - Required: header word held stable; no pop while valid=0; burst completes with exactly len_r pops.
- Enable gating:
  - Stimulus: enable cleared during DATA.
  - Required: the current burst finishes; no further HDR until enable=1.
